// File: rtl/ctrl_fsm.sv
// Multi-cycle control sequencer: fetch wait, decode, ALU latency, timed pulse,
// sync/fproc handshakes and a terminal done state for one processor core.
module ctrl_fsm #(
  parameter int MEM_READ_CYCLES = 2,
  parameter int ALU_LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd_opcode,
  input  logic       pulse_time_hit,
  input  logic       sync_in_valid,
  input  logic       fproc_in_valid,
  output logic [2:0] alu_opcode,
  output logic       alu_in0_sel,
  output logic       alu_in1_sel,
  output logic       c_strobe_enable,
  output logic       reg_write_en,
  output logic       qclk_load_en,
  output logic       instr_ptr_en,
  output logic [1:0] instr_ptr_load_en,
  output logic       sync_out_ready,
  output logic       fproc_out_ready,
  output logic       done
);

  localparam logic [4:0] PULSE_I       = 5'd1;
  localparam logic [4:0] REG_WRITE_I   = 5'd2;
  localparam logic [4:0] REG_I_ALU     = 5'd3;
  localparam logic [4:0] REG_ALU       = 5'd4;
  localparam logic [4:0] JUMP_I        = 5'd5;
  localparam logic [4:0] JUMP_COND_I   = 5'd6;
  localparam logic [4:0] INC_QCLK      = 5'd7;
  localparam logic [4:0] INC_QCLK_I    = 5'd8;
  localparam logic [4:0] PULSE_TIMED_I = 5'd9;
  localparam logic [4:0] SYNC_I        = 5'd10;
  localparam logic [4:0] FPROC_I       = 5'd11;
  localparam logic [4:0] DONE_I        = 5'd12;

  localparam logic ALU_IN0_CMD_SEL  = 1'b0;
  localparam logic ALU_IN0_REG_SEL  = 1'b1;
  localparam logic ALU_IN1_REG_SEL  = 1'b0;
  localparam logic ALU_IN1_QCLK_SEL = 1'b1;

  localparam logic [1:0] INSTR_PTR_LOAD_EN_NONE = 2'b00;
  localparam logic [1:0] INSTR_PTR_LOAD_EN_CMD  = 2'b01;
  localparam logic [1:0] INSTR_PTR_LOAD_EN_ALU  = 2'b10;

  localparam int MAX_CYCLES = (MEM_READ_CYCLES > ALU_LATENCY) ? MEM_READ_CYCLES : ALU_LATENCY;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALU_LAST = CNT_W'(ALU_LATENCY - 1);

  typedef enum logic [2:0] {
    MEM_WAIT,
    DECODE,
    ALU_PROC,
    PULSE_WAIT,
    SYNC_WAIT,
    FPROC_WAIT,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [4:0]       alu_class_reg, alu_class_next;
  logic [4:0]       cmd_class;

  assign cmd_class = cmd_opcode[7:3];

  // {alu_in0_sel, alu_in1_sel} for each ALU-using class; 0 otherwise.
  function automatic logic [1:0] alu_sels(input logic [4:0] cls);
    case (cls)
      REG_I_ALU:   alu_sels = {ALU_IN0_CMD_SEL, ALU_IN1_REG_SEL};
      REG_ALU:     alu_sels = {ALU_IN0_REG_SEL, ALU_IN1_REG_SEL};
      JUMP_COND_I: alu_sels = {ALU_IN0_CMD_SEL, ALU_IN1_REG_SEL};
      INC_QCLK:    alu_sels = {ALU_IN0_REG_SEL, ALU_IN1_QCLK_SEL};
      INC_QCLK_I:  alu_sels = {ALU_IN0_CMD_SEL, ALU_IN1_QCLK_SEL};
      default:     alu_sels = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= MEM_WAIT;
      cnt_reg       <= '0;
      alu_class_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      alu_class_reg <= alu_class_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = '0;
    alu_class_next    = alu_class_reg;
    alu_opcode        = cmd_opcode[2:0];
    alu_in0_sel       = 1'b0;
    alu_in1_sel       = 1'b0;
    c_strobe_enable   = 1'b0;
    reg_write_en      = 1'b0;
    qclk_load_en      = 1'b0;
    instr_ptr_en      = 1'b0;
    instr_ptr_load_en = INSTR_PTR_LOAD_EN_NONE;
    sync_out_ready    = 1'b0;
    fproc_out_ready   = 1'b0;
    done              = 1'b0;

    case (state_reg)
      MEM_WAIT: begin
        if (cnt_reg == MEM_LAST) state_next = DECODE;
        else                     cnt_next   = cnt_reg + CNT_W'(1);
      end
      DECODE: begin
        alu_class_next = cmd_class;
        case (cmd_class)
          PULSE_I: begin
            c_strobe_enable = 1'b1;
            instr_ptr_en    = 1'b1;
            state_next      = MEM_WAIT;
          end
          REG_WRITE_I: begin
            reg_write_en = 1'b1;
            instr_ptr_en = 1'b1;
            state_next   = MEM_WAIT;
          end
          JUMP_I: begin
            instr_ptr_load_en = INSTR_PTR_LOAD_EN_CMD;
            state_next        = MEM_WAIT;
          end
          REG_I_ALU, REG_ALU, JUMP_COND_I, INC_QCLK, INC_QCLK_I: begin
            {alu_in0_sel, alu_in1_sel} = alu_sels(cmd_class);
            state_next = ALU_PROC;
          end
          PULSE_TIMED_I: state_next = PULSE_WAIT;
          SYNC_I:        state_next = SYNC_WAIT;
          FPROC_I:       state_next = FPROC_WAIT;
          DONE_I:        state_next = DONE;
          default: begin
            instr_ptr_en = 1'b1;
            state_next   = MEM_WAIT;
          end
        endcase
      end
      ALU_PROC: begin
        // Class is latched at decode so the selects stay stable for the whole latency.
        {alu_in0_sel, alu_in1_sel} = alu_sels(alu_class_reg);
        if (cnt_reg == ALU_LAST) begin
          case (alu_class_reg)
            REG_I_ALU, REG_ALU:   reg_write_en      = 1'b1;
            INC_QCLK, INC_QCLK_I: qclk_load_en      = 1'b1;
            JUMP_COND_I:          instr_ptr_load_en = INSTR_PTR_LOAD_EN_ALU;
            default:              ;
          endcase
          instr_ptr_en = 1'b1;
          state_next   = MEM_WAIT;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      PULSE_WAIT: begin
        if (pulse_time_hit) begin
          c_strobe_enable = 1'b1;
          instr_ptr_en    = 1'b1;
          state_next      = MEM_WAIT;
        end
      end
      SYNC_WAIT: begin
        sync_out_ready = 1'b1;
        if (sync_in_valid) begin
          instr_ptr_en = 1'b1;
          state_next   = MEM_WAIT;
        end
      end
      FPROC_WAIT: begin
        fproc_out_ready = 1'b1;
        if (fproc_in_valid) begin
          reg_write_en = 1'b1;
          instr_ptr_en = 1'b1;
          state_next   = MEM_WAIT;
        end
      end
      DONE: done = 1'b1;
      default: state_next = MEM_WAIT;
    endcase

    // Reset wins over any handshake completing in the same cycle.
    if (reset) begin
      c_strobe_enable   = 1'b0;
      reg_write_en      = 1'b0;
      qclk_load_en      = 1'b0;
      instr_ptr_en      = 1'b0;
      instr_ptr_load_en = INSTR_PTR_LOAD_EN_NONE;
    end
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: expected per-cycle output vectors are queued
// per instruction and popped as the DUT is sampled each cycle.
module tb_ctrl_fsm;

  localparam int MRC     = 2;
  localparam int ALU_LAT = 3;

  localparam logic [4:0] PULSE_I       = 5'd1;
  localparam logic [4:0] REG_WRITE_I   = 5'd2;
  localparam logic [4:0] REG_I_ALU     = 5'd3;
  localparam logic [4:0] REG_ALU       = 5'd4;
  localparam logic [4:0] JUMP_I        = 5'd5;
  localparam logic [4:0] JUMP_COND_I   = 5'd6;
  localparam logic [4:0] INC_QCLK      = 5'd7;
  localparam logic [4:0] INC_QCLK_I    = 5'd8;
  localparam logic [4:0] PULSE_TIMED_I = 5'd9;
  localparam logic [4:0] SYNC_I        = 5'd10;
  localparam logic [4:0] FPROC_I       = 5'd11;
  localparam logic [4:0] DONE_I        = 5'd12;
  localparam logic [4:0] UNKNOWN_I     = 5'd31;

  // Flag bits: {in0, in1, strobe, reg_wr, qclk_ld, ip_en, ip_load[1:0], sync_rdy, fproc_rdy, done}
  localparam logic [10:0] F_NONE    = 11'h000;
  localparam logic [10:0] F_IN0     = 11'h400;
  localparam logic [10:0] F_IN1     = 11'h200;
  localparam logic [10:0] F_STB     = 11'h100;
  localparam logic [10:0] F_RGW     = 11'h080;
  localparam logic [10:0] F_QLD     = 11'h040;
  localparam logic [10:0] F_IPE     = 11'h020;
  localparam logic [10:0] F_IPL_ALU = 11'h010;
  localparam logic [10:0] F_IPL_CMD = 11'h008;
  localparam logic [10:0] F_SYR     = 11'h004;
  localparam logic [10:0] F_FPR     = 11'h002;
  localparam logic [10:0] F_DN      = 11'h001;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cmd_opcode;
  logic       pulse_time_hit, sync_in_valid, fproc_in_valid;
  logic [2:0] alu_opcode;
  logic       alu_in0_sel, alu_in1_sel, c_strobe_enable, reg_write_en, qclk_load_en;
  logic       instr_ptr_en, sync_out_ready, fproc_out_ready, done;
  logic [1:0] instr_ptr_load_en;

  always #5 clk = ~clk;

  ctrl_fsm #(.MEM_READ_CYCLES(MRC), .ALU_LATENCY(ALU_LAT)) dut (
    .clk(clk), .reset(reset), .cmd_opcode(cmd_opcode),
    .pulse_time_hit(pulse_time_hit), .sync_in_valid(sync_in_valid),
    .fproc_in_valid(fproc_in_valid), .alu_opcode(alu_opcode),
    .alu_in0_sel(alu_in0_sel), .alu_in1_sel(alu_in1_sel),
    .c_strobe_enable(c_strobe_enable), .reg_write_en(reg_write_en),
    .qclk_load_en(qclk_load_en), .instr_ptr_en(instr_ptr_en),
    .instr_ptr_load_en(instr_ptr_load_en), .sync_out_ready(sync_out_ready),
    .fproc_out_ready(fproc_out_ready), .done(done)
  );

  wire [13:0] outs = {alu_opcode, alu_in0_sel, alu_in1_sel, c_strobe_enable, reg_write_en,
                      qclk_load_en, instr_ptr_en, instr_ptr_load_en, sync_out_ready,
                      fproc_out_ready, done};

  logic [13:0] exp_q[$];
  logic [13:0] exp_v;
  int checks = 0;
  int errors = 0;

  function automatic logic [13:0] ev(input logic [7:0] opc, input logic [10:0] flags);
    return {opc[2:0], flags};
  endfunction

  task automatic push_mem(input logic [7:0] opc);
    for (int i = 0; i < MRC; i++) exp_q.push_back(ev(opc, F_NONE));
  endtask

  // Drive one cycle's inputs at the falling edge and settle before sampling.
  task automatic cyc(input logic [7:0] opc, input logic rst, input logic sv,
                     input logic fv, input logic hit);
    @(negedge clk);
    cmd_opcode = opc; reset = rst; sync_in_valid = sv;
    fproc_in_valid = fv; pulse_time_hit = hit;
    #1;
  endtask

  task automatic test_reset;
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ev(8'h00, F_NONE));
    exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin
      errors++; $display("FAIL reset_state got=%b exp=%b", outs, exp_v);
    end
    $display("reset: outputs sampled after reset");
  endtask

  task automatic test_single_cycle;
    logic [4:0]  cls [4] = '{PULSE_I, REG_WRITE_I, UNKNOWN_I, JUMP_I};
    logic [10:0] fin [4] = '{F_STB | F_IPE, F_RGW | F_IPE, F_IPE, F_IPL_CMD};
    logic [7:0]  op;
    for (int t = 0; t < 4; t++) begin
      op = {cls[t], 3'(t + 1)};
      push_mem(op);
      exp_q.push_back(ev(op, fin[t]));
      for (int i = 0; i < MRC + 1; i++) begin
        cyc(op, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = exp_q.pop_front(); checks++;
        if (outs !== exp_v) begin
          errors++; $display("FAIL single_cycle cls=%0d cyc=%0d got=%b exp=%b", cls[t], i, outs, exp_v);
        end
      end
      $display("single_cycle: class %0d retired in %0d cycles", cls[t], MRC + 1);
    end
  endtask

  task automatic test_alu_classes;
    logic [4:0]  cls [5] = '{REG_ALU, REG_I_ALU, INC_QCLK, INC_QCLK_I, JUMP_COND_I};
    logic [10:0] sel [5] = '{F_IN0, F_NONE, F_IN0 | F_IN1, F_IN1, F_NONE};
    logic [10:0] fin [5] = '{F_RGW, F_RGW, F_QLD, F_QLD, F_IPL_ALU};
    logic [7:0]  op;
    for (int t = 0; t < 5; t++) begin
      op = {cls[t], 3'(7 - t)};
      push_mem(op);
      exp_q.push_back(ev(op, sel[t]));
      for (int k = 0; k < ALU_LAT - 1; k++) exp_q.push_back(ev(op, sel[t]));
      exp_q.push_back(ev(op, sel[t] | fin[t] | F_IPE));
      for (int i = 0; i < MRC + 1 + ALU_LAT; i++) begin
        cyc(op, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = exp_q.pop_front(); checks++;
        if (outs !== exp_v) begin
          errors++; $display("FAIL alu cls=%0d cyc=%0d got=%b exp=%b", cls[t], i, outs, exp_v);
        end
      end
      $display("alu: class %0d retired in %0d cycles", cls[t], MRC + 1 + ALU_LAT);
    end
  endtask

  task automatic test_sync;
    logic [7:0] op;
    logic       sv;
    op = {SYNC_I, 3'd1};
    push_mem(op);
    exp_q.push_back(ev(op, F_NONE));
    for (int k = 0; k < 10; k++) exp_q.push_back(ev(op, F_SYR));
    exp_q.push_back(ev(op, F_SYR | F_IPE));
    for (int i = 0; i < MRC + 12; i++) begin
      // sync_in_valid pulsed during fetch/decode must be ignored
      sv = (i < MRC + 1) || (i == MRC + 11);
      cyc(op, 1'b0, sv, 1'b0, 1'b0);
      exp_v = exp_q.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL sync cyc=%0d got=%b exp=%b", i, outs, exp_v);
      end
    end
    $display("sync: released after 10 wait cycles");
  endtask

  task automatic test_fproc;
    logic [7:0] op;
    logic       fv;
    op = {FPROC_I, 3'd6};
    push_mem(op);
    exp_q.push_back(ev(op, F_NONE));
    for (int k = 0; k < 5; k++) exp_q.push_back(ev(op, F_FPR));
    exp_q.push_back(ev(op, F_FPR | F_RGW | F_IPE));
    for (int i = 0; i < MRC + 7; i++) begin
      fv = (i < MRC + 1) || (i == MRC + 6);
      cyc(op, 1'b0, 1'b0, fv, 1'b0);
      exp_v = exp_q.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL fproc cyc=%0d got=%b exp=%b", i, outs, exp_v);
      end
    end
    $display("fproc: result accepted after 5 wait cycles");
  endtask

  task automatic test_pulse_timed;
    logic [7:0] op;
    logic       hit;
    op = {PULSE_TIMED_I, 3'd3};
    push_mem(op);
    exp_q.push_back(ev(op, F_NONE));
    for (int k = 0; k < 7; k++) exp_q.push_back(ev(op, F_NONE));
    exp_q.push_back(ev(op, F_STB | F_IPE));
    for (int i = 0; i < MRC + 9; i++) begin
      hit = (i < MRC + 1) || (i == MRC + 8);
      cyc(op, 1'b0, 1'b0, 1'b0, hit);
      exp_v = exp_q.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL pulse_timed cyc=%0d got=%b exp=%b", i, outs, exp_v);
      end
    end
    $display("pulse_timed: strobe after 7 low cycles");
    // hit already high: retires in MRC+2 cycles
    op = {PULSE_TIMED_I, 3'd4};
    push_mem(op);
    exp_q.push_back(ev(op, F_NONE));
    exp_q.push_back(ev(op, F_STB | F_IPE));
    for (int i = 0; i < MRC + 2; i++) begin
      cyc(op, 1'b0, 1'b0, 1'b0, 1'b1);
      exp_v = exp_q.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL pulse_timed_hit cyc=%0d got=%b exp=%b", i, outs, exp_v);
      end
    end
    $display("pulse_timed: hit already high retired in %0d cycles", MRC + 2);
  endtask

  task automatic test_reset_mid_wait;
    logic [7:0] op;
    logic [7:0] op2;
    logic       rst;
    op  = {SYNC_I, 3'd2};
    op2 = {PULSE_I, 3'd5};
    push_mem(op);
    exp_q.push_back(ev(op, F_NONE));
    for (int k = 0; k < 3; k++) exp_q.push_back(ev(op, F_SYR));
    exp_q.push_back(ev(op, F_SYR));   // reset and sync_in_valid together: no advance
    push_mem(op2);
    exp_q.push_back(ev(op2, F_STB | F_IPE));
    for (int i = 0; i < MRC + 5 + MRC + 1; i++) begin
      rst = (i == MRC + 4);
      cyc((i <= MRC + 4) ? op : op2, rst, rst, 1'b0, 1'b0);
      exp_v = exp_q.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL reset_mid_wait cyc=%0d got=%b exp=%b", i, outs, exp_v);
      end
    end
    $display("reset_mid_wait: sequencer restarted and retired a pulse");
  endtask

  task automatic test_done;
    logic [7:0] op;
    op = {DONE_I, 3'd7};
    push_mem(op);
    exp_q.push_back(ev(op, F_NONE));
    for (int k = 0; k < 100; k++) exp_q.push_back(ev(op, F_DN));
    for (int i = 0; i < MRC + 101; i++) begin
      cyc(op, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exp_v = exp_q.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL done cyc=%0d got=%b exp=%b", i, outs, exp_v);
      end
    end
    exp_q.push_back(ev(op, F_DN));
    exp_q.push_back(ev(8'h00, F_NONE));
    for (int i = 0; i < 2; i++) begin
      cyc((i == 0) ? op : 8'h00, (i == 0), 1'b0, 1'b0, 1'b0);
      exp_v = exp_q.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL done_reset cyc=%0d got=%b exp=%b", i, outs, exp_v);
      end
    end
    $display("done: held 100 cycles, cleared by reset");
  endtask

  initial begin
    reset = 1'b1; cmd_opcode = 8'h00;
    pulse_time_hit = 1'b0; sync_in_valid = 1'b0; fproc_in_valid = 1'b0;
    test_reset;
    test_single_cycle;
    test_alu_classes;
    test_sync;
    test_fproc;
    test_pulse_timed;
    test_reset_mid_wait;
    test_done;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
